// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: bus word/lane types, FIFO entry layout,
// bus size encodings and the drain FSM states.
package store_buffer_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  m_wen_t;

  typedef struct packed {
    word_t  addr;
    m_wen_t en;
    word_t  wd;
  } sb_entry_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } sb_state_t;

endpackage

// File: rtl/sb_size_decode.sv
// Byte-lane enables to bus transfer size and low address bits; purely combinational.
// Unlisted lane patterns fall through as a word access at the original offset.
module sb_size_decode
  import store_buffer_pkg::*;
(
  input  m_wen_t     en,
  input  logic [1:0] addr_lo,
  output logic [1:0] size,
  output logic [1:0] bus_lo
);

  always_comb begin
    size   = SIZE_WORD;
    bus_lo = addr_lo;
    case (en)
      4'b1111: begin size = SIZE_WORD; bus_lo = 2'b00; end
      4'b0011: begin size = SIZE_HALF; bus_lo = 2'b00; end
      4'b1100: begin size = SIZE_HALF; bus_lo = 2'b10; end
      4'b0001: begin size = SIZE_BYTE; bus_lo = 2'b00; end
      4'b0010: begin size = SIZE_BYTE; bus_lo = 2'b01; end
      4'b0100: begin size = SIZE_BYTE; bus_lo = 2'b10; end
      4'b1000: begin size = SIZE_BYTE; bus_lo = 2'b11; end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer draining committed stores in order to the data bus; a push can request
// the bus the next cycle, push_ready drops only when full. Load forwarding under STORE_BUF_FWD_EN.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push_valid,
  output logic        push_ready,
  input  word_t       push_addr,
  input  m_wen_t      push_en,
  input  word_t       push_wd,
  input  logic        ld_valid,
  input  word_t       ld_addr,
  input  m_wen_t      ld_en,
  output logic        ld_stall,
  output logic        ld_fwd_valid,
  output word_t       ld_fwd_data,
  output logic        empty,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output word_t       data_addr,
  output word_t       data_wdata,
  output m_wen_t      data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);

  sb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PTR_W:0]   rd_ptr, wr_ptr, rd_nxt, wr_nxt;
  sb_state_t        state;
  logic             full, fifo_empty, push_fire, pop, remain;
  sb_entry_t        push_ent, head_src;
  logic [1:0]       nxt_size, nxt_lo;
  logic [DEPTH-1:0] match;
  logic [1:0]       unused_ld_lo;

  assign full       = (rd_ptr ^ wr_ptr) == {1'b1, {PTR_W{1'b0}}};
  assign fifo_empty = rd_ptr == wr_ptr;
  assign push_ready = !full;
  assign push_fire  = push_valid && !full;
  assign pop        = data_data_ok && ((state == S_REQ && data_addr_ok) || state == S_WAIT);
  assign rd_nxt     = rd_ptr + {{PTR_W{1'b0}}, pop};
  assign wr_nxt     = wr_ptr + {{PTR_W{1'b0}}, push_fire};
  assign remain     = rd_nxt != wr_nxt;
  assign push_ent   = '{addr: push_addr, en: push_en, wd: push_wd};
  // The next head may be the store being written this very cycle.
  assign head_src   = (rd_nxt == wr_ptr) ? push_ent : mem[rd_nxt[PTR_W-1:0]];
  assign empty      = fifo_empty && state == S_IDLE;
  assign data_wr    = data_req;
  assign unused_ld_lo = ld_addr[1:0];

  sb_size_decode u_size_decode (
    .en      (head_src.en),
    .addr_lo (head_src.addr[1:0]),
    .size    (nxt_size),
    .bus_lo  (nxt_lo)
  );

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr[PTR_W-1:0]] <= push_ent;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      vld        <= '0;
      state      <= S_IDLE;
      data_req   <= 1'b0;
      data_size  <= '0;
      data_addr  <= '0;
      data_wdata <= '0;
      data_wstrb <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_nxt;
      if (pop)       vld[rd_ptr[PTR_W-1:0]] <= 1'b0;
      if (push_fire) vld[wr_ptr[PTR_W-1:0]] <= 1'b1;
      // Head stays buffered (and visible to loads) until its write completes.
      if (state == S_REQ && data_addr_ok && !data_data_ok) begin
        state    <= S_WAIT;
        data_req <= 1'b0;
      end else if (state == S_IDLE || pop) begin
        if (remain) begin
          state      <= S_REQ;
          data_req   <= 1'b1;
          data_size  <= nxt_size;
          data_addr  <= {head_src.addr[31:2], nxt_lo};
          data_wdata <= head_src.wd;
          data_wstrb <= head_src.en;
        end else begin
          state    <= S_IDLE;
          data_req <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = vld[i] && (mem[i].addr[31:2] == ld_addr[31:2]) && |(mem[i].en & ld_en);
    end
  end

`ifdef STORE_BUF_FWD_EN
  m_wen_t           cov;
  word_t            merged;
  logic [PTR_W-1:0] fidx;
  logic             fwd_ok;

  // Walk oldest to newest so the newest matching store wins each lane.
  always_comb begin
    cov    = '0;
    merged = '0;
    fidx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fidx = rd_ptr[PTR_W-1:0] + PTR_W'(k);
      if (match[fidx]) begin
        for (int b = 0; b < 4; b++) begin
          if (mem[fidx].en[b] && ld_en[b]) begin
            cov[b]           = 1'b1;
            merged[8*b +: 8] = mem[fidx].wd[8*b +: 8];
          end
        end
      end
    end
  end

  assign fwd_ok       = |match && (cov == ld_en);
  assign ld_fwd_valid = ld_valid && fwd_ok;
  assign ld_fwd_data  = ld_fwd_valid ? merged : '0;
  assign ld_stall     = ld_valid && |match && !fwd_ok;
`else
  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = '0;
  assign ld_stall     = ld_valid && |match;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: table of single stores plus scripted corner sequences;
// bus transactions are checked against a queue of expected writes.
module tb_store_buffer;

  logic        clk, resetn;
  logic        push_valid, push_ready;
  logic [31:0] push_addr, push_wd;
  logic [3:0]  push_en;
  logic        ld_valid, ld_stall, ld_fwd_valid;
  logic [31:0] ld_addr, ld_fwd_data;
  logic [3:0]  ld_en;
  logic        empty, data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .push_valid(push_valid), .push_ready(push_ready), .push_addr(push_addr),
    .push_en(push_en), .push_wd(push_wd),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_en(ld_en), .ld_stall(ld_stall),
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
    .empty(empty), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  en;
    logic [31:0] wd;
    logic [1:0]  size;
    logic [31:0] baddr;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strb;
    logic [31:0] wd;
  } bus_t;

  vec_t vecs[8];
  bus_t sb[$];
  bus_t mon_e;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write check when the bus accepts a request (sampled on the falling edge).
  always @(negedge clk) begin
    if (resetn && data_req && data_addr_ok) begin
      if (sb.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL bus_unexpected: addr %h with no write expected", data_addr);
      end else begin
        mon_e = sb.pop_front();
        chk("bus_addr", data_addr, mon_e.addr);
        chk("bus_size", 32'(data_size), 32'(mon_e.size));
        chk("bus_strb", 32'(data_wstrb), 32'(mon_e.strb));
        chk("bus_wdata", data_wdata, mon_e.wd);
        chk("bus_wr", 32'(data_wr), 1);
      end
    end
  end

  task automatic push_st(input logic [31:0] a, input logic [3:0] e, input logic [31:0] w,
                         input logic [1:0] sz, input logic [31:0] ba);
    chk("push_ready_before", 32'(push_ready), 1);
    push_valid = 1'b1; push_addr = a; push_en = e; push_wd = w;
    tick();
    push_valid = 1'b0;
    sb.push_back('{addr: ba, size: sz, strb: e, wd: w});
  endtask

  task automatic drain();
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    for (int i = 0; i < 50 && !empty; i++) tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    chk("drain_empty", 32'(empty), 1);
  endtask

  task automatic ld_chk(input string name, input logic [31:0] a, input logic [3:0] e,
                        input logic st, input logic fv, input logic [31:0] fd);
    ld_valid = 1'b1; ld_addr = a; ld_en = e;
    #1;
    chk({name, "_stall"}, 32'(ld_stall), 32'(st));
    chk({name, "_fwd_valid"}, 32'(ld_fwd_valid), 32'(fv));
    chk({name, "_fwd_data"}, ld_fwd_data, fd);
    ld_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; push_valid = 1'b0; push_addr = '0; push_en = '0; push_wd = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_en = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0;

    vecs[0] = '{32'h1000_0003, 4'b1000, 32'hAB00_0000, 2'd0, 32'h1000_0003};
    vecs[1] = '{32'h1000_0010, 4'b1111, 32'h1234_5678, 2'd2, 32'h1000_0010};
    vecs[2] = '{32'h2000_0002, 4'b1100, 32'hBEEF_0000, 2'd1, 32'h2000_0002};
    vecs[3] = '{32'h2000_0004, 4'b0011, 32'h0000_CAFE, 2'd1, 32'h2000_0004};
    vecs[4] = '{32'h3000_0001, 4'b0010, 32'h0000_5A00, 2'd0, 32'h3000_0001};
    vecs[5] = '{32'h3000_0006, 4'b0100, 32'h0077_0000, 2'd0, 32'h3000_0006};
    vecs[6] = '{32'h4000_0008, 4'b0001, 32'h0000_0099, 2'd0, 32'h4000_0008};
    vecs[7] = '{32'h5000_0003, 4'b1111, 32'hDEAD_BEEF, 2'd2, 32'h5000_0000};

    #2;
    chk("rst_push_ready", 32'(push_ready), 1);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_data_req", 32'(data_req), 0);
    chk("rst_ld_stall", 32'(ld_stall), 0);
    chk("rst_fwd_valid", 32'(ld_fwd_valid), 0);
    chk("rst_fwd_data", ld_fwd_data, 0);
    chk("rst_data_addr", data_addr, 0);
    chk("rst_data_size", 32'(data_size), 0);
    tick();
    resetn = 1'b1;
    tick();

    // Single stores: request the cycle after push, complete with addr_ok+data_ok together.
    for (int i = 0; i < 8; i++) begin
      push_st(vecs[i].addr, vecs[i].en, vecs[i].wd, vecs[i].size, vecs[i].baddr);
      chk("vec_req", 32'(data_req), 1);
      chk("vec_size", 32'(data_size), 32'(vecs[i].size));
      chk("vec_addr", data_addr, vecs[i].baddr);
      chk("vec_strb", 32'(data_wstrb), 32'(vecs[i].en));
      chk("vec_busy", 32'(empty), 0);
      data_addr_ok = 1'b1; data_data_ok = 1'b1;
      tick();
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      chk("vec_empty", 32'(empty), 1);
      chk("vec_req_off", 32'(data_req), 0);
    end

    // Fill to full with the bus stalled, then free one slot.
    for (int k = 0; k < 4; k++)
      push_st(32'h6000_0000 + 32'(k * 4), 4'hF, 32'h6600_0000 + 32'(k), 2'd2,
              32'h6000_0000 + 32'(k * 4));
    chk("full_ready", 32'(push_ready), 0);
    push_valid = 1'b1; push_addr = 32'h6000_0010; push_en = 4'hF; push_wd = 32'h6600_0004;
    tick();
    chk("full_hold", 32'(push_ready), 0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    chk("fill_wait_req", 32'(data_req), 0);
    tick();
    tick();
    chk("fill_still_full", 32'(push_ready), 0);
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    chk("ready_after_pop", 32'(push_ready), 1);
    chk("next_head_req", 32'(data_req), 1);
    tick();
    push_valid = 1'b0;
    sb.push_back('{addr: 32'h6000_0010, size: 2'd2, strb: 4'hF, wd: 32'h6600_0004});
    chk("refull_ready", 32'(push_ready), 0);
    drain();

    // Back-to-back stores with delayed completion.
    push_st(32'h0000_2002, 4'b1100, 32'hBEEF_0000, 2'd1, 32'h0000_2002);
    push_st(32'h0000_2004, 4'b1111, 32'h0102_0304, 2'd2, 32'h0000_2004);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    chk("wait_req_low", 32'(data_req), 0);
    tick();
    chk("wait_req_low2", 32'(data_req), 0);
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    chk("second_req", 32'(data_req), 1);
    chk("second_size", 32'(data_size), 2);
    chk("second_addr", data_addr, 32'h0000_2004);
    drain();

    // Load conflict against a buffered byte store, held through WAIT.
    push_st(32'h0000_3000, 4'b0001, 32'h0000_0011, 2'd0, 32'h0000_3000);
    ld_chk("ld_overlap", 32'h0000_3000, 4'b1111, 1'b1, 1'b0, 32'h0);
    ld_chk("ld_lane_miss", 32'h0000_3000, 4'b0010, 1'b0, 1'b0, 32'h0);
    ld_chk("ld_word_miss", 32'h0000_3004, 4'b0001, 1'b0, 1'b0, 32'h0);
    chk("ld_no_valid", 32'(ld_stall), 0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    ld_chk("ld_inflight", 32'h0000_3000, 4'b1111, 1'b1, 1'b0, 32'h0);
    data_data_ok = 1'b1;
    ld_chk("ld_at_dataok", 32'h0000_3000, 4'b1111, 1'b1, 1'b0, 32'h0);
    tick();
    data_data_ok = 1'b0;
    ld_chk("ld_after_dataok", 32'h0000_3000, 4'b1111, 1'b0, 1'b0, 32'h0);

    // Overlapping word + byte stores: merged forward, or stall without forwarding.
    push_st(32'h0000_4000, 4'b1111, 32'h1111_1111, 2'd2, 32'h0000_4000);
    push_st(32'h0000_4001, 4'b0010, 32'h0000_2200, 2'd0, 32'h0000_4001);
`ifdef STORE_BUF_FWD_EN
    ld_chk("fwd_word", 32'h0000_4000, 4'b1111, 1'b0, 1'b1, 32'h1111_2211);
    ld_chk("fwd_byte", 32'h0000_4000, 4'b0010, 1'b0, 1'b1, 32'h0000_2200);
`else
    ld_chk("fwd_word", 32'h0000_4000, 4'b1111, 1'b1, 1'b0, 32'h0);
    ld_chk("fwd_byte", 32'h0000_4000, 4'b0010, 1'b1, 1'b0, 32'h0);
`endif
    ld_chk("fwd_miss", 32'h0000_4004, 4'b1111, 1'b0, 1'b0, 32'h0);
    drain();

    // Reset while a request is outstanding discards the buffer.
    push_st(32'h0000_5000, 4'b1111, 32'h5555_5555, 2'd2, 32'h0000_5000);
    push_st(32'h0000_5004, 4'b1111, 32'h6666_6666, 2'd2, 32'h0000_5004);
    chk("pre_rst_req", 32'(data_req), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_req", 32'(data_req), 0);
    chk("midrst_ready", 32'(push_ready), 1);
    chk("midrst_empty", 32'(empty), 1);
    sb.delete();
    tick();
    resetn = 1'b1;
    tick();
    chk("post_rst_req", 32'(data_req), 0);
    push_st(32'h0000_7002, 4'b0100, 32'h0033_0000, 2'd0, 32'h0000_7002);
    drain();
    chk("sb_leftover", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
